// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the data-cache port arbiter.
package cache_arb_pkg;

  localparam int NUM_REQ         = 4;
  localparam int SEL_W           = 2;
  localparam int TIMEOUT_DEFAULT = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/cache_port_arbiter_if.sv
// Requester/cache-side signal bundle of the data-cache port arbiter.
interface cache_port_arbiter_if;
  import cache_arb_pkg::*;

  // Handshake: req[i] is a level held until ack[i] pulses. cache_req is held
  // high for the whole transaction and drops the cycle after the one-cycle
  // cache_done strobe is sampled. gnt/sel name the owner while it is served.
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [SEL_W-1:0]   sel;
  logic               cache_req;
  logic               cache_done;
  logic [NUM_REQ-1:0] ack;
  logic               err;

  modport slave (
    input  req, cache_done,
    output gnt, sel, cache_req, ack, err
  );

  modport master (
    output req, cache_done,
    input  gnt, sel, cache_req, ack, err
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first set req bit at or above ptr, wrapping.
module rr_pick
  import cache_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               any,
  output logic [SEL_W-1:0]   idx,
  output logic [NUM_REQ-1:0] onehot
);

  logic [SEL_W-1:0] cand;

  // Scan from the farthest offset down so the nearest hit to ptr wins last.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

  assign onehot = any ? (NUM_REQ'(1) << idx) : '0;

endmodule

// File: rtl/cache_port_arbiter.sv
// Round-robin owner of the shared 32-bit data-cache port across four requesters.
// Optional BUSY watchdog enabled by defining CACHE_ARB_TIMEOUT_EN.
module cache_port_arbiter
  import cache_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  cache_port_arbiter_if.slave  bus,
  output state_t               dbg_state
);

  state_t             state, state_n;
  logic [SEL_W-1:0]   ptr, ptr_n;
  logic [SEL_W-1:0]   sel_q, sel_n;
  logic [NUM_REQ-1:0] gnt_q, gnt_n;
  logic [NUM_REQ-1:0] ack_q, ack_n;
  logic               creq_q, creq_n;

  logic               pick_any;
  logic [SEL_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick_onehot;

  rr_pick u_pick (
    .req    (bus.req),
    .ptr    (ptr),
    .any    (pick_any),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

`ifdef CACHE_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             err_q, err_n;
  logic             expired;

  // cnt holds the number of BUSY cycles already completed.
  assign expired = (cnt == CNT_W'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    sel_n   = sel_q;
    gnt_n   = gnt_q;
    ack_n   = '0;
    creq_n  = 1'b0;
`ifdef CACHE_ARB_TIMEOUT_EN
    cnt_n   = cnt;
    err_n   = 1'b0;
`endif
    case (state)
      IDLE: begin
        gnt_n = '0;
        if (pick_any) begin
          state_n = BUSY;
          gnt_n   = pick_onehot;
          sel_n   = pick_idx;
          ptr_n   = pick_idx + 1'b1;
          creq_n  = 1'b1;
`ifdef CACHE_ARB_TIMEOUT_EN
          cnt_n   = '0;
`endif
        end
      end
      BUSY: begin
        creq_n = 1'b1;
`ifdef CACHE_ARB_TIMEOUT_EN
        cnt_n  = cnt + 1'b1;
`endif
        if (bus.cache_done) begin
          state_n = ACK;
          creq_n  = 1'b0;
          ack_n   = gnt_q;
        end
`ifdef CACHE_ARB_TIMEOUT_EN
        else if (expired) begin
          state_n = ACK;
          creq_n  = 1'b0;
          ack_n   = gnt_q;
          err_n   = 1'b1;
        end
`endif
      end
      ACK: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      ptr    <= '0;
      sel_q  <= '0;
      gnt_q  <= '0;
      ack_q  <= '0;
      creq_q <= 1'b0;
`ifdef CACHE_ARB_TIMEOUT_EN
      cnt    <= '0;
      err_q  <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      sel_q  <= sel_n;
      gnt_q  <= gnt_n;
      ack_q  <= ack_n;
      creq_q <= creq_n;
`ifdef CACHE_ARB_TIMEOUT_EN
      cnt    <= cnt_n;
      err_q  <= err_n;
`endif
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.cache_req = creq_q;
  assign bus.ack       = ack_q;
`ifdef CACHE_ARB_TIMEOUT_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif
  assign dbg_state     = state;

endmodule
